mimo_frame_sequencer: RTL and testbench
=======================================

// Module: mimo_frame_sequencer
// PURPOSE
// - Sequences one detection frame into MIMO_detector: N_ANT channel rows (flag=channel), then CFG vectors (flag=data).
// - Holds off when the detector deasserts o_in_ready, or when MAX_INFLIGHT data vectors are outstanding.
// - Waits for all results to drain, then signals frame done. Sits between host/DMA streams and MIMO_detector.
// PARAMETERS
// - INT_W        6     integer bits per fixed-point component
// - FRAC_W       10    fraction bits per component
// - N_ANT        4     antennas; rows per channel matrix and complex entries per row/vector
// - SYM_W        3     detected symbol width per antenna
// - MAX_INFLIGHT 8     max data vectors issued but not yet answered (power of 2 not required)
// - VEC_W        16    width of vector count/index
// - FLAG_CH      1'b1  flagChannelorData value marking a channel row (data = ~FLAG_CH)
// PORTS (ROW_W = (INT_W+FRAC_W)*N_ANT*2 = 128; RES_W = SYM_W*N_ANT = 12)
// - Clk           in   1      clock
// - Reset         in   1      synchronous, active-high reset
// - cfg_start     in   1      pulse: begin frame (ignored unless busy=0)
// - cfg_nvec      in   VEC_W  data vectors in frame, sampled on accepted cfg_start
// - ch_valid/ch_ready  in/out 1  channel row handshake
// - ch_data       in   ROW_W  channel row
// - dv_valid/dv_ready  in/out 1  data vector handshake
// - dv_data       in   ROW_W  received vector
// - det_in_valid  out  1      -> MIMO_detector.i_in_valid
// - det_flag      out  1      -> flagChannelorData
// - det_data      out  ROW_W  -> InData
// - det_in_ready  in   1      <- o_in_ready
// - det_out_valid in   1      <- OutputReady
// - det_out_data  in   RES_W  <- OutData
// - res_valid     out  1      registered result strobe (no backpressure)
// - res_data      out  RES_W  detected symbols
// - res_idx       out  VEC_W  vector index of result, 0-based within the frame
// - busy          out  1      frame in progress (state != IDLE)
// - frame_done    out  1      one-cycle pulse when the last result is delivered
// - err_spurious  out  1      sticky: det_out_valid seen with zero outstanding
// BEHAVIOUR
// - Reset (sync): every output 0; state IDLE; all counters 0; err_spurious cleared. An in-progress frame is dropped.
// - Output stage: det_* are one register stage. A beat transfers when det_in_valid && det_in_ready.
//   - Output reg may load when !det_in_valid || det_in_ready.
//   - det_data/det_flag hold while det_in_valid && !det_in_ready.
// - Upstream ready:
//   - ch_ready = (st==LOAD_CH) && load_ok && row_cnt issued < N_ANT.
//   - dv_ready = (st==STREAM) && load_ok && (outstanding + pending) < MAX_INFLIGHT && issued < nvec.
// - FSM:
//   - IDLE -> LOAD_CH on cfg_start; latch nvec; clear row_cnt, issued, res_idx.
//   - LOAD_CH: transfer N_ANT rows with det_flag=FLAG_CH.
//     - After the last row transfers to the detector: go to STREAM, or to DRAIN if nvec==0.
//   - STREAM: issue vectors with det_flag=~FLAG_CH; issued++ on each accepted dv beat.
//     - When the final vector transfers to the detector -> DRAIN.
//   - DRAIN: wait for outstanding==0 && res_idx==nvec -> IDLE, pulsing frame_done in the same cycle as the state change.
//     - If nvec==0: frame_done is pulsed one cycle after the DRAIN entry.
// - outstanding: +1 on a data beat transfer to the detector, -1 on det_out_valid.
//   - Both in the same cycle: unchanged.
//   - Range 0..MAX_INFLIGHT; never wraps.
//   - det_out_valid at 0: no decrement; set err_spurious; result still forwarded.
// - Results:
//   - res_valid/res_data are det_out_valid/det_out_data delayed one cycle.
//   - res_idx = count of prior results in the frame; increments after each res_valid.
//   - Results arriving in IDLE: forwarded and flagged as spurious.
// - cfg_start while busy: ignored, no side effects.
// - Channel rows are never interleaved with data vectors in the same frame; the row order is preserved.
// STRUCTURE
// - Shared package mimo_pkg: ROW_W, RES_W, FLAG_CH, state enum {IDLE, LOAD_CH, STREAM, DRAIN}.
// - Sub-module mimo_det_skid: the one-entry det_* output register with valid/ready hold logic.
// - Top level: FSM, row/issue/outstanding/result counters.
// TESTING
// - Reset, then start with nvec=11 and det_in_ready always 1:
//   - 4 flag=CH beats, then 11 data beats; 11 results with res_idx 0..10.
//   - frame_done fires once; busy returns to 0.
// - det_in_ready low for 5 cycles mid-LOAD_CH: det_data is stable throughout; no row is lost or duplicated; all 4 rows arrive in order.
// - MAX_INFLIGHT=8, detector stub withholds results: dv_ready drops after 8 issued.
//   - Releasing 1 result allows exactly 1 more data beat.
// - nvec=0: only 4 channel rows; frame_done pulses with no results; busy drops.
// - det_out_valid in IDLE: err_spurious=1 and stays set until Reset; outstanding stays 0.
// - Assert Reset during STREAM with 3 outstanding:
//   - Next cycle: all outputs 0, IDLE.
//   - A new cfg_start with nvec=2 completes normally.

Source files
------------

// File: rtl/mimo_pkg.sv
// Shared types and default widths for the MIMO detector frame sequencer.
package mimo_pkg;

  localparam int DEF_INT_W        = 6;
  localparam int DEF_FRAC_W       = 10;
  localparam int DEF_N_ANT        = 4;
  localparam int DEF_SYM_W        = 3;
  localparam int DEF_MAX_INFLIGHT = 8;
  localparam int DEF_VEC_W        = 16;

  // Channel row / received vector width: N_ANT complex fixed-point entries.
  localparam int ROW_W = (DEF_INT_W + DEF_FRAC_W) * DEF_N_ANT * 2;
  // Detector result width: one symbol per antenna.
  localparam int RES_W = DEF_SYM_W * DEF_N_ANT;

  // flagChannelorData value for a channel row; data vectors use the inverse.
  localparam logic FLAG_CH = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_CH = 2'd1,
    STREAM  = 2'd2,
    DRAIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mimo_det_skid.sv
// One-entry output register toward the detector. Holds its beat while the
// detector stalls and reports when a new beat may be loaded.
module mimo_det_skid
  import mimo_pkg::*;
#(
  parameter int DATA_W = ROW_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_valid,
  input  logic              load_flag,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ok,
  output logic              out_valid,
  output logic              out_flag,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              xfer
);

  // The register is free when empty or when its beat leaves this cycle.
  assign load_ok = !out_valid || out_ready;
  assign xfer    = out_valid && out_ready;

  // Load a new beat (or go empty) only when free; otherwise hold everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_flag  <= 1'b0;
      out_data  <= '0;
    end else if (load_ok) begin
      out_valid <= load_valid;
      if (load_valid) begin
        out_flag <= load_flag;
        out_data <= load_data;
      end
    end
  end

endmodule

// File: rtl/mimo_frame_sequencer.sv
// Sequences one detection frame into the MIMO detector: N_ANT channel rows,
// then nvec data vectors, with an in-flight limit, then waits for results.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame; cfg_start accepted here only
// LOAD_CH | forwarding the N_ANT channel rows
// STREAM  | forwarding data vectors, bounded by MAX_INFLIGHT outstanding
// DRAIN   | all beats sent; waiting for the remaining results
module mimo_frame_sequencer #(
  parameter  int   INT_W        = 6,
  parameter  int   FRAC_W       = 10,
  parameter  int   N_ANT        = 4,
  parameter  int   SYM_W        = 3,
  parameter  int   MAX_INFLIGHT = 8,
  parameter  int   VEC_W        = 16,
  parameter  logic FLAG_CH      = 1'b1,
  localparam int   ROW_W        = (INT_W + FRAC_W) * N_ANT * 2,
  localparam int   RES_W        = SYM_W * N_ANT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cfg_start,
  input  logic [VEC_W-1:0] cfg_nvec,
  input  logic             ch_valid,
  output logic             ch_ready,
  input  logic [ROW_W-1:0] ch_data,
  input  logic             dv_valid,
  output logic             dv_ready,
  input  logic [ROW_W-1:0] dv_data,
  output logic             det_in_valid,
  output logic             det_flag,
  output logic [ROW_W-1:0] det_data,
  input  logic             det_in_ready,
  input  logic             det_out_valid,
  input  logic [RES_W-1:0] det_out_data,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic [VEC_W-1:0] res_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             err_spurious
);

  import mimo_pkg::*;

  localparam int ROW_CNT_W = $clog2(N_ANT + 1);
  localparam int OUT_W     = $clog2(MAX_INFLIGHT + 1);

  localparam logic [ROW_CNT_W-1:0] ROWS     = ROW_CNT_W'(N_ANT);
  localparam logic [OUT_W-1:0]     MAX_OUT  = OUT_W'(MAX_INFLIGHT);
  localparam logic [OUT_W:0]       MAX_FLY  = (OUT_W + 1)'(MAX_INFLIGHT);
  localparam logic [OUT_W-1:0]     ONE_OUT  = OUT_W'(1);
  localparam logic [VEC_W-1:0]     ONE_VEC  = VEC_W'(1);
  localparam logic [ROW_CNT_W-1:0] ONE_ROW  = ROW_CNT_W'(1);

  seq_state_e st_q, st_d;
  logic       done_d;

  logic [VEC_W-1:0]     nvec_q;
  logic [VEC_W-1:0]     issued_q;
  logic [VEC_W-1:0]     res_idx_q;
  logic [ROW_CNT_W-1:0] row_cnt_q;
  logic [OUT_W-1:0]     outstanding_q;

  logic             stage_free;
  logic             stage_xfer;
  logic             ld_valid;
  logic             ld_flag;
  logic [ROW_W-1:0] ld_data;

  logic           start_acc;
  logic           ch_acc;
  logic           dv_acc;
  logic           data_pending;
  logic           data_xfer;
  logic           out_dec;
  logic           spurious;
  logic [OUT_W:0] inflight;

  assign start_acc = cfg_start && (st_q == IDLE);

  // A data beat sitting in the output register is not yet outstanding but
  // must still count against the in-flight limit.
  assign data_pending = det_in_valid && (det_flag != FLAG_CH);
  assign data_xfer    = stage_xfer && (det_flag != FLAG_CH);
  assign inflight     = {1'b0, outstanding_q} + (OUT_W + 1)'(data_pending);

  assign ch_ready = (st_q == LOAD_CH) && stage_free && (row_cnt_q < ROWS);
  assign dv_ready = (st_q == STREAM) && stage_free && (inflight < MAX_FLY)
                    && (issued_q < nvec_q);

  assign ch_acc = ch_valid && ch_ready;
  assign dv_acc = dv_valid && dv_ready;

  // ch_ready and dv_ready are never high together, so the mux is exclusive.
  assign ld_valid = ch_acc || dv_acc;
  assign ld_flag  = ch_acc ? FLAG_CH : ~FLAG_CH;
  assign ld_data  = ch_acc ? ch_data : dv_data;

  assign out_dec  = det_out_valid && (outstanding_q != '0);
  assign spurious = det_out_valid && (outstanding_q == '0);

  assign busy    = (st_q != IDLE);
  assign res_idx = res_idx_q;

  mimo_det_skid #(
    .DATA_W (ROW_W)
  ) u_skid (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_valid (ld_valid),
    .load_flag  (ld_flag),
    .load_data  (ld_data),
    .load_ok    (stage_free),
    .out_valid  (det_in_valid),
    .out_flag   (det_flag),
    .out_data   (det_data),
    .out_ready  (det_in_ready),
    .xfer       (stage_xfer)
  );

  // Next-state logic; phase changes wait until the last beat of the phase
  // has actually left the output register.
  always_comb begin
    st_d   = st_q;
    done_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (cfg_start) st_d = LOAD_CH;
      end
      LOAD_CH: begin
        if ((row_cnt_q == ROWS) && stage_free) begin
          st_d = (nvec_q == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if ((issued_q == nvec_q) && stage_free) st_d = DRAIN;
      end
      DRAIN: begin
        if ((outstanding_q == '0) && (res_idx_q == nvec_q)) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State register and frame_done pulse, aligned with the return to IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q       <= IDLE;
      frame_done <= 1'b0;
    end else begin
      st_q       <= st_d;
      frame_done <= done_d;
    end
  end

  // Frame bookkeeping: vector count, rows and vectors accepted upstream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      nvec_q    <= '0;
      row_cnt_q <= '0;
      issued_q  <= '0;
    end else if (start_acc) begin
      nvec_q    <= cfg_nvec;
      row_cnt_q <= '0;
      issued_q  <= '0;
    end else begin
      if (ch_acc) row_cnt_q <= row_cnt_q + ONE_ROW;
      if (dv_acc) issued_q  <= issued_q + ONE_VEC;
    end
  end

  // Outstanding data vectors at the detector; a result with nothing
  // outstanding is flagged instead of underflowing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      outstanding_q <= '0;
      err_spurious  <= 1'b0;
    end else begin
      unique case ({data_xfer, out_dec})
        2'b10: if (outstanding_q != MAX_OUT) outstanding_q <= outstanding_q + ONE_OUT;
        2'b01: outstanding_q <= outstanding_q - ONE_OUT;
        default: ;
      endcase
      if (spurious) err_spurious <= 1'b1;
    end
  end

  // Results are forwarded one cycle late; the index counts delivered results.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx_q <= '0;
    end else begin
      res_valid <= det_out_valid;
      res_data  <= det_out_data;
      if (start_acc)      res_idx_q <= '0;
      else if (res_valid) res_idx_q <= res_idx_q + ONE_VEC;
    end
  end

endmodule

// File: tb/tb_mimo_frame_sequencer.sv
// Bench for mimo_frame_sequencer with a detector stub and scoreboards.
module tb_mimo_frame_sequencer;
  import mimo_pkg::*;

  localparam int VEC_W = 16;
  typedef logic [ROW_W:0] cmp_t;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             cfg_start = 1'b0;
  logic [VEC_W-1:0] cfg_nvec = '0;
  logic             ch_valid = 1'b0;
  logic             ch_ready;
  logic [ROW_W-1:0] ch_data = '0;
  logic             dv_valid = 1'b0;
  logic             dv_ready;
  logic [ROW_W-1:0] dv_data = '0;
  logic             det_in_valid;
  logic             det_flag;
  logic [ROW_W-1:0] det_data;
  logic             det_in_ready = 1'b1;
  logic             det_out_valid = 1'b0;
  logic [RES_W-1:0] det_out_data = '0;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [VEC_W-1:0] res_idx;
  logic             busy;
  logic             frame_done;
  logic             err_spurious;

  always #5 Clk = ~Clk;

  mimo_frame_sequencer u_dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .cfg_start     (cfg_start),
    .cfg_nvec      (cfg_nvec),
    .ch_valid      (ch_valid),
    .ch_ready      (ch_ready),
    .ch_data       (ch_data),
    .dv_valid      (dv_valid),
    .dv_ready      (dv_ready),
    .dv_data       (dv_data),
    .det_in_valid  (det_in_valid),
    .det_flag      (det_flag),
    .det_data      (det_data),
    .det_in_ready  (det_in_ready),
    .det_out_valid (det_out_valid),
    .det_out_data  (det_out_data),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_idx       (res_idx),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_spurious  (err_spurious)
  );

  int n_cmp = 0;
  int n_bad = 0;

  cmp_t             det_exp_q[$];
  logic [RES_W-1:0] res_exp_q[$];
  logic [RES_W-1:0] stub_q[$];

  int ch_beats = 0, dv_beats = 0, dv_acc = 0, res_cnt = 0, done_cnt = 0;
  int exp_idx = 0;

  bit               stub_hold = 1'b0;
  int               stub_credit = 0;
  bit               spur_req = 1'b0;
  logic [RES_W-1:0] spur_data = '0;

  task automatic chk(input string tag, input cmp_t obs, input cmp_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expected detector beats and results are pushed when the
  // upstream handshake completes and popped when the DUT produces them.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (ch_valid && ch_ready) det_exp_q.push_back({FLAG_CH, ch_data});
      if (dv_valid && dv_ready) begin
        det_exp_q.push_back({~FLAG_CH, dv_data});
        res_exp_q.push_back(dv_data[RES_W-1:0]);
        dv_acc++;
      end
      if (det_in_valid && det_in_ready) begin
        if (det_exp_q.size() == 0) chk("det_unexpected", cmp_t'(1), cmp_t'(0));
        else chk("det_beat", {det_flag, det_data}, det_exp_q.pop_front());
        if (det_flag == FLAG_CH) ch_beats++;
        else begin
          dv_beats++;
          stub_q.push_back(det_data[RES_W-1:0]);
        end
      end
      if (res_valid) begin
        if (res_exp_q.size() == 0) chk("res_unexpected", cmp_t'(1), cmp_t'(0));
        else chk("res_data", cmp_t'(res_data), cmp_t'(res_exp_q.pop_front()));
        chk("res_idx", cmp_t'(res_idx), cmp_t'(exp_idx));
        exp_idx++;
        res_cnt++;
      end
      if (frame_done) done_cnt++;
    end
  end

  // Detector stub: answers each data beat with its low bits, optionally
  // holding results back until given credits.
  always @(posedge Clk) begin
    #1;
    det_out_valid = 1'b0;
    det_out_data  = '0;
    if (Reset) begin
      stub_q.delete();
      spur_req = 1'b0;
    end else if (spur_req) begin
      det_out_valid = 1'b1;
      det_out_data  = spur_data;
      spur_req      = 1'b0;
    end else if (stub_q.size() > 0 && (!stub_hold || stub_credit > 0)) begin
      det_out_valid = 1'b1;
      det_out_data  = stub_q.pop_front();
      if (stub_hold) stub_credit--;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic start_frame(input int nvec);
    cfg_nvec  = VEC_W'(nvec);
    cfg_start = 1'b1;
    exp_idx   = 0;
    @(posedge Clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic feed(input bit is_dv, input int n, input string tag);
    logic [ROW_W-1:0] d;
    bit acc;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < ROW_W / 32; w++) d[w*32 +: 32] = $urandom;
      if (is_dv) begin dv_valid = 1'b1; dv_data = d; end
      else       begin ch_valid = 1'b1; ch_data = d; end
      acc = 1'b0;
      for (int k = 0; k < 400 && !acc; k++) begin
        @(negedge Clk);
        acc = is_dv ? dv_ready : ch_ready;
        @(posedge Clk);
        #1;
      end
      if (!acc) chk({tag, "_accept_timeout"}, cmp_t'(0), cmp_t'(1));
    end
    ch_valid = 1'b0;
    dv_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int k = 0; k < 500; k++) begin
      @(negedge Clk);
      if (done_cnt > base) break;
      @(posedge Clk);
      #1;
    end
    cycles(4);
    chk({tag, "_done_pulses"}, cmp_t'(done_cnt - base), cmp_t'(1));
    @(negedge Clk);
    chk({tag, "_busy_low"}, cmp_t'(busy), cmp_t'(0));
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      cmp_t'(busy), cmp_t'(0));
    chk({tag, "_det_valid"}, cmp_t'(det_in_valid), cmp_t'(0));
    chk({tag, "_det_flag"},  cmp_t'(det_flag), cmp_t'(0));
    chk({tag, "_det_data"},  cmp_t'(det_data), cmp_t'(0));
    chk({tag, "_res_valid"}, cmp_t'(res_valid), cmp_t'(0));
    chk({tag, "_res_data"},  cmp_t'(res_data), cmp_t'(0));
    chk({tag, "_res_idx"},   cmp_t'(res_idx), cmp_t'(0));
    chk({tag, "_done"},      cmp_t'(frame_done), cmp_t'(0));
    chk({tag, "_err"},       cmp_t'(err_spurious), cmp_t'(0));
    chk({tag, "_ch_ready"},  cmp_t'(ch_ready), cmp_t'(0));
    chk({tag, "_dv_ready"},  cmp_t'(dv_ready), cmp_t'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ch, b_dv, b_res, b_done, b_acc;
    logic [ROW_W-1:0] snap;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_all_zero("reset");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cycles(2);

    // Full frame, nvec=11, detector always ready
    b_ch = ch_beats; b_dv = dv_beats; b_res = res_cnt; b_done = done_cnt;
    start_frame(11);
    @(negedge Clk);
    chk("f1_busy", cmp_t'(busy), cmp_t'(1));
    @(posedge Clk);
    #1;
    feed(1'b0, 4, "f1_ch");
    feed(1'b1, 11, "f1_dv");
    wait_done(b_done, "f1");
    chk("f1_ch_beats", cmp_t'(ch_beats - b_ch), cmp_t'(4));
    chk("f1_dv_beats", cmp_t'(dv_beats - b_dv), cmp_t'(11));
    chk("f1_results", cmp_t'(res_cnt - b_res), cmp_t'(11));

    // Detector stall for 5 cycles during LOAD_CH
    b_ch = ch_beats; b_done = done_cnt;
    start_frame(2);
    fork
      feed(1'b0, 4, "f2_ch");
      begin
        cycles(2);
        det_in_ready = 1'b0;
        @(negedge Clk);
        snap = det_data;
        chk("f2_stall_valid", cmp_t'(det_in_valid), cmp_t'(1));
        for (int k = 0; k < 4; k++) begin
          @(posedge Clk);
          @(negedge Clk);
          chk("f2_stall_hold", cmp_t'(det_data), cmp_t'(snap));
        end
        @(posedge Clk);
        #1;
        det_in_ready = 1'b1;
      end
    join
    feed(1'b1, 2, "f2_dv");
    wait_done(b_done, "f2");
    chk("f2_ch_beats", cmp_t'(ch_beats - b_ch), cmp_t'(4));

    // In-flight limit with the detector withholding results
    stub_hold = 1'b1;
    stub_credit = 0;
    b_res = res_cnt; b_done = done_cnt;
    start_frame(12);
    feed(1'b0, 4, "f3_ch");
    b_acc = dv_acc;
    fork
      feed(1'b1, 12, "f3_dv");
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge Clk);
          if (dv_acc - b_acc >= 8) break;
        end
        cycles(5);
        @(negedge Clk);
        chk("f3_limit_ready", cmp_t'(dv_ready), cmp_t'(0));
        chk("f3_limit_count", cmp_t'(dv_acc - b_acc), cmp_t'(8));
        @(posedge Clk);
        #1;
        stub_credit = 1;
        cycles(6);
        @(negedge Clk);
        chk("f3_one_more", cmp_t'(dv_acc - b_acc), cmp_t'(9));
        chk("f3_ready_again_low", cmp_t'(dv_ready), cmp_t'(0));
        @(posedge Clk);
        #1;
        stub_hold = 1'b0;
      end
    join
    wait_done(b_done, "f3");
    chk("f3_results", cmp_t'(res_cnt - b_res), cmp_t'(12));

    // Empty frame: channel rows only
    b_ch = ch_beats; b_dv = dv_beats; b_res = res_cnt; b_done = done_cnt;
    start_frame(0);
    feed(1'b0, 4, "f4_ch");
    wait_done(b_done, "f4");
    chk("f4_ch_beats", cmp_t'(ch_beats - b_ch), cmp_t'(4));
    chk("f4_dv_beats", cmp_t'(dv_beats - b_dv), cmp_t'(0));
    chk("f4_results", cmp_t'(res_cnt - b_res), cmp_t'(0));
    chk("f4_err_clear", cmp_t'(err_spurious), cmp_t'(0));

    // Spurious result while IDLE
    spur_data = 12'h5a5;
    res_exp_q.push_back(12'h5a5);
    spur_req = 1'b1;
    cycles(3);
    @(negedge Clk);
    chk("spur_err", cmp_t'(err_spurious), cmp_t'(1));
    chk("spur_outstanding", cmp_t'(u_dut.outstanding_q), cmp_t'(0));
    cycles(6);
    @(negedge Clk);
    chk("spur_err_sticky", cmp_t'(err_spurious), cmp_t'(1));
    chk("spur_busy", cmp_t'(busy), cmp_t'(0));
    @(posedge Clk);
    #1;

    // Reset during STREAM with 3 outstanding
    stub_hold = 1'b1;
    stub_credit = 0;
    start_frame(6);
    feed(1'b0, 4, "f5_ch");
    feed(1'b1, 3, "f5_dv");
    cycles(4);
    @(negedge Clk);
    chk("f5_outstanding", cmp_t'(u_dut.outstanding_q), cmp_t'(3));
    chk("f5_busy", cmp_t'(busy), cmp_t'(1));
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk_all_zero("f5_reset");
    chk("f5_reset_outstanding", cmp_t'(u_dut.outstanding_q), cmp_t'(0));
    cycles(1);
    det_exp_q.delete();
    res_exp_q.delete();
    stub_q.delete();
    stub_hold = 1'b0;
    stub_credit = 0;
    exp_idx = 0;
    cycles(1);
    Reset = 1'b0;
    cycles(2);

    b_res = res_cnt; b_done = done_cnt;
    start_frame(2);
    feed(1'b0, 4, "f6_ch");
    feed(1'b1, 2, "f6_dv");
    wait_done(b_done, "f6");
    chk("f6_results", cmp_t'(res_cnt - b_res), cmp_t'(2));

    chk("end_det_queue", cmp_t'(det_exp_q.size()), cmp_t'(0));
    chk("end_res_queue", cmp_t'(res_exp_q.size()), cmp_t'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
